// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver (LSB first), centre-sampled, no oversampling.
//
// The baud constant is shared with the matching UART transmitter so that a
// Tx/Rx pair built from the same CLKS_PER_BIT value interoperates.
//
// Parameters
//   CLKS_PER_BIT : system clocks per bit (>= 4), 1042 = 10 MHz / 9600 baud
//   DATA_BITS    : data bits per frame, 5..8
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst_       in   asynchronous active-high reset
//   rxd        in   serial line, asynchronous to clk, idle high
//   dout       out  received byte, first data bit in bit 0, unused MSBs 0
//   dout_valid out  dout holds an unconsumed byte
//   dout_ready in   consumer accepts dout when dout_valid & dout_ready
//   busy       out  a frame is in progress (state != IDLE)
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, unconsumed byte was overwritten
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] C_HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    C_LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // Registers
    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CW-1:0]        r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_dout;
    logic                 r_dout_valid;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_overrun;

    // Next-state wires
    logic                 w_rx_s;
    state_t               w_state_nxt;
    logic [CW-1:0]        w_baud_nxt;
    logic [2:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_commit;
    logic                 w_ferr;
    logic [7:0]           w_dout_nxt;
    logic                 w_valid_nxt;
    logic                 w_overrun_nxt;

    assign w_rx_s = r_sync2;

    // Two-flop synchronizer on the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame state register, counters, shift register and output register.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= '0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_baud_cnt   <= w_baud_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_valid_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_err  <= w_ferr;
            r_overrun    <= w_overrun_nxt;
        end
    end

    // Frame sequencing: start validation, centre sampling of data and stop bits.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_commit    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                // Re-check the line half a bit in: a high level means a glitch.
                if (r_baud_cnt == C_HALF_M1) begin
                    w_baud_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == C_BIT_M1) begin
                    w_baud_nxt = '0;
                    // Shift in from the MSB side so the first bit lands in bit 0.
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_baud_cnt == C_BIT_M1) begin
                    w_baud_nxt = '0;
                    if (w_rx_s) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                // Park on a break until the line returns to idle.
                w_baud_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_HIGH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // One-entry output register: a commit always wins over a consume.
    always_comb begin
        w_dout_nxt    = r_dout;
        w_valid_nxt   = r_dout_valid;
        w_overrun_nxt = 1'b0;
        if (w_commit) begin
            w_dout_nxt    = 8'(r_shift);
            w_valid_nxt   = 1'b1;
            w_overrun_nxt = r_dout_valid & ~dout_ready;
        end else if (r_dout_valid && dout_ready) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_dout_valid;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8).
// A bit-serial transmitter task drives rxd; each byte expected on the output
// is queued when its frame is sent and compared when the DUT hands it over.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_;
    logic       rxd;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         fall_cyc = 0;
    int         last_rise_cyc = 0;
    int         n_valid_cycles = 0;
    int         n_valid_rise = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    logic       prev_valid = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .rxd        (rxd),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_) begin
            if (dout_valid) n_valid_cycles = n_valid_cycles + 1;
            if (dout_valid && !prev_valid) begin
                n_valid_rise  = n_valid_rise + 1;
                last_rise_cyc = cyc;
            end
            if (frame_err) n_ferr = n_ferr + 1;
            if (overrun)   n_ovr  = n_ovr + 1;
            if (dout_valid && dout_ready) begin
                n_total = n_total + 1;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got dout=%h, required no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) $display("FAIL sb_dout: got %h, required %h", dout, e);
                    else n_pass = n_pass + 1;
                end
            end
            prev_valid = dout_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic clear_counts();
        n_valid_cycles = 0;
        n_valid_rise   = 0;
        n_ferr         = 0;
        n_ovr          = 0;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Bench model of the team UART transmitter: start, 8 data LSB first, stop.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_total = n_total + 1;
        if (got !== req) $display("FAIL %s: got %0d, required %0d", name, got, req);
        else n_pass = n_pass + 1;
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        rxd = 1'b1;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total = n_total + 1;
        if ({dout, dout_valid, busy, frame_err, overrun} !== 12'h000)
            $display("FAIL reset_in: got %h, required 000", {dout, dout_valid, busy, frame_err, overrun});
        else n_pass = n_pass + 1;
        rst_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total = n_total + 1;
        if ({dout, dout_valid, busy, frame_err, overrun} !== 12'h000)
            $display("FAIL reset_after: got %h, required 000", {dout, dout_valid, busy, frame_err, overrun});
        else n_pass = n_pass + 1;
    endtask

    task automatic test_single_frame();
        clear_counts();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("single_latency", last_rise_cyc - fall_cyc, 8 + 9 * 16 + 3);
        chk("single_valid_cycles", n_valid_cycles, 1);
        chk("single_q_empty", exp_q.size(), 0);
        chk("single_busy", int'(busy), 0);
        n_total = n_total + 1;
        if (dout !== 8'hA5) $display("FAIL single_dout: got %h, required a5", dout);
        else n_pass = n_pass + 1;
    endtask

    task automatic test_start_glitch();
        int k;
        @(posedge clk);
        #1;
        clear_counts();
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_busy_hi", int'(busy), 1);
        rxd = 1'b1;
        k = 0;
        while (busy !== 1'b0 && k < 6) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("glitch_busy_lo_11", int'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_no_valid", n_valid_rise, 0);
        chk("glitch_no_ferr", n_ferr, 0);
    endtask

    task automatic test_frame_error();
        clear_counts();
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_pulses", n_ferr, 1);
        chk("ferr_no_valid", n_valid_rise, 0);
        chk("ferr_busy_held", int'(busy), 1);
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ferr_busy_sync", int'(busy), 1);
        @(posedge clk);
        #1;
        chk("ferr_busy_released", int'(busy), 0);
    endtask

    task automatic test_overrun();
        clear_counts();
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        n_total = n_total + 1;
        if ({dout, dout_valid} !== {8'h11, 1'b1})
            $display("FAIL ovr_first: got dout=%h valid=%b, required 11/1", dout, dout_valid);
        else n_pass = n_pass + 1;
        chk("ovr_none_yet", n_ovr, 0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        n_total = n_total + 1;
        if ({dout, dout_valid} !== {8'h22, 1'b1})
            $display("FAIL ovr_second: got dout=%h valid=%b, required 22/1", dout, dout_valid);
        else n_pass = n_pass + 1;
        chk("ovr_pulses", n_ovr, 1);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_valid_cleared", int'(dout_valid), 0);
        chk("ovr_q_empty", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (4 * CPB + CPB / 2) @(posedge clk);
        #1;
        chk("rmf_busy_before", int'(busy), 1);
        #2;
        rst_ = 1'b1;
        #1;
        n_total = n_total + 1;
        if ({dout, dout_valid, busy, frame_err, overrun} !== 12'h000)
            $display("FAIL rmf_async: got %h, required 000", {dout, dout_valid, busy, frame_err, overrun});
        else n_pass = n_pass + 1;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_counts();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rmf_q_empty", exp_q.size(), 0);
        chk("rmf_valid_once", n_valid_rise, 1);
        chk("rmf_no_flags", n_ferr + n_ovr, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] lb [4];
        lb = '{8'h00, 8'hFF, 8'h55, 8'h80};
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(lb[i]);
            send_frame(lb[i], 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("loop_q_empty", exp_q.size(), 0);
        chk("loop_count", n_valid_rise, 4);
        chk("loop_no_ferr", n_ferr, 0);
        chk("loop_no_ovr", n_ovr, 0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_start_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
